// File: rtl/rv32i_stage_sequencer.sv
// -----------------------------------------------------------------------------
// rv32i_stage_sequencer
//   Multicycle stage controller for the rv32i core. Walks each instruction
//   through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK, raises the per-stage
//   enables, runs the instruction and data memory handshakes, bounds data
//   accesses with a timeout, lets a pending interrupt squash the memory access,
//   and parks in HALTED at an instruction boundary on request.
//
// Parameters
//   MEM_TIMEOUT    max MEMORY cycles without i_data_ack (0 = wait forever)
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_halt              stop at the next instruction boundary
//   i_inst_ack          instruction word returned (used in FETCH only)
//   i_data_ack          load/store completed (used in MEMORY only)
//   i_opcode_load/store decoded instruction class (sampled in EXECUTE)
//   i_irq_pending       enabled interrupt pending (sampled in EXECUTE)
//   o_stage             one-hot {WB,MEM,EX,DEC,FETCH}, 0 when halted
//   o_inst_req          instruction fetch request
//   o_data_req/o_data_we data request and its write qualifier
//   o_writeback         writeback-stage enable
//   o_instret           retire pulse
//   o_bus_err           data timeout pulse
//   o_halted            idle in HALTED
//
// Every output is a decode of registered state and flags only.
// -----------------------------------------------------------------------------
module rv32i_stage_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_halt,
  input  logic       i_inst_ack,
  input  logic       i_data_ack,
  input  logic       i_opcode_load,
  input  logic       i_opcode_store,
  input  logic       i_irq_pending,
  output logic [4:0] o_stage,
  output logic       o_inst_req,
  output logic       o_data_req,
  output logic       o_data_we,
  output logic       o_writeback,
  output logic       o_instret,
  output logic       o_bus_err,
  output logic       o_halted
);

  // Timeout counter width; never narrower than one bit.
  localparam int unsigned CW_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  // Counter value seen in the last permitted MEMORY cycle.
  localparam int unsigned LAST_I = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [CW-1:0] CNT_LAST = LAST_I[CW-1:0];

  typedef enum logic [2:0] {
    ST_HALTED    = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5
  } state_e;

  state_e        state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          we_q,     we_d;
  logic          squash_q, squash_d;
  logic          err_q,    err_d;

  // State and flag registers; reset parks the sequencer in HALTED.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_HALTED;
      cnt_q    <= {CW{1'b0}};
      we_q     <= 1'b0;
      squash_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      squash_q <= squash_d;
      err_q    <= err_d;
    end
  end

  // Next-state, timeout counter and flag logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    squash_d = squash_q;
    err_d    = err_q;
    case (state_q)
      ST_HALTED: begin
        if (!i_halt) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_FETCH: begin
        if (i_inst_ack) begin
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        // An interrupt wins over the memory access: skip straight to writeback.
        if (i_irq_pending) begin
          state_d  = ST_WRITEBACK;
          squash_d = 1'b1;
        end else if (i_opcode_load || i_opcode_store) begin
          state_d = ST_MEMORY;
          we_d    = i_opcode_store;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        // An ack in the last allowed cycle is checked first, so it is not an error.
        if (i_data_ack) begin
          state_d = ST_WRITEBACK;
        end else if ((MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = ST_WRITEBACK;
          err_d   = 1'b1;
        end else if (MEM_TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_WRITEBACK: begin
        squash_d = 1'b0;
        err_d    = 1'b0;
        we_d     = 1'b0;
        if (i_halt) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d  = ST_HALTED;
        squash_d = 1'b0;
        err_d    = 1'b0;
        we_d     = 1'b0;
      end
    endcase
  end

  // Output decode of registered state and flags.
  always_comb begin
    o_stage     = 5'b00000;
    o_inst_req  = 1'b0;
    o_data_req  = 1'b0;
    o_data_we   = 1'b0;
    o_writeback = 1'b0;
    o_instret   = 1'b0;
    o_bus_err   = 1'b0;
    o_halted    = 1'b0;
    case (state_q)
      ST_HALTED: begin
        o_halted = 1'b1;
      end
      ST_FETCH: begin
        o_stage    = 5'b00001;
        o_inst_req = 1'b1;
      end
      ST_DECODE: begin
        o_stage = 5'b00010;
      end
      ST_EXECUTE: begin
        o_stage = 5'b00100;
      end
      ST_MEMORY: begin
        o_stage    = 5'b01000;
        o_data_req = 1'b1;
        o_data_we  = we_q;
      end
      ST_WRITEBACK: begin
        o_stage     = 5'b10000;
        o_writeback = 1'b1;
        o_instret   = ~squash_q & ~err_q;
        o_bus_err   = err_q;
      end
      default: begin
        o_halted = 1'b1;
      end
    endcase
  end

endmodule
